// File: rtl/regfile_n.sv
// regfile_n
// ---------------------------------------------------------------------------
// Parametrised architectural register file: DEPTH = 2**ADDR_W registers of
// WIDTH bits, one synchronous byte-enabled write port and two independent
// combinational read ports.
//
// Parameters
//   WIDTH    data width in bits (multiple of 8)
//   ADDR_W   address width
//   ZERO_REG 1 = register 0 is hardwired to zero and ignores writes
//   BYPASS   1 = a read of the register being written this cycle returns the
//            post-write (merged) value; 0 = it returns the stored value
//
// Ports
//   clk       clock, rising edge
//   clr       asynchronous active-low reset, clears every register
//   we        write enable
//   wa        write address
//   wd        write data
//   wbe       byte enables, bit k selects wd[8k+7:8k]
//   ra1/rd1   read port 1 address / data
//   ra2/rd2   read port 2 address / data
// ---------------------------------------------------------------------------
module regfile_n #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic [WIDTH/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]    ra1,
  output logic [WIDTH-1:0]     rd1,
  input  logic [ADDR_W-1:0]    ra2,
  output logic [WIDTH-1:0]     rd2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = WIDTH / 8;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic              HAS_ZERO  = (ZERO_REG != 0);
  localparam logic              HAS_BYP   = (BYPASS != 0);

  logic [WIDTH-1:0] mem_r [DEPTH];

  logic             wr_ok_s;
  logic [WIDTH-1:0] merged_s;
  logic             hit1_s;
  logic             hit2_s;

  // Byte-lane merge: enabled lanes from the new data, others keep the old value.
  function automatic logic [WIDTH-1:0] merge_lanes(
    input logic [WIDTH-1:0] old_v,
    input logic [WIDTH-1:0] new_v,
    input logic [NB-1:0]    be
  );
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Read-port selection: zero register wins over bypass, bypass over storage.
  function automatic logic [WIDTH-1:0] read_sel(
    input logic [ADDR_W-1:0] ra,
    input logic [WIDTH-1:0]  stored,
    input logic              hit,
    input logic [WIDTH-1:0]  merged
  );
    logic [WIDTH-1:0] res;
    if (HAS_ZERO && (ra == ADDR_ZERO)) begin
      res = {WIDTH{1'b0}};
    end else if (hit) begin
      res = merged;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Write qualification and the post-write value of the target register.
  // clr gates the write so that bypass cannot leak data while in reset.
  always_comb begin
    wr_ok_s  = 1'b0;
    merged_s = merge_lanes(mem_r[wa], wd, wbe);
    if (clr && we && !(HAS_ZERO && (wa == ADDR_ZERO))) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Bypass hit detection for both read ports.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    if (HAS_BYP && wr_ok_s) begin
      hit1_s = (ra1 == wa);
      hit2_s = (ra2 == wa);
    end else begin
      hit1_s = 1'b0;
      hit2_s = 1'b0;
    end
  end

  // Register storage: async clear, byte-enabled write of the addressed entry.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[wa] <= merged_s;
    end else begin
      mem_r[wa] <= mem_r[wa];
    end
  end

  // Read port 1.
  always_comb begin
    rd1 = {WIDTH{1'b0}};
    rd1 = read_sel(ra1, mem_r[ra1], hit1_s, merged_s);
  end

  // Read port 2.
  always_comb begin
    rd2 = {WIDTH{1'b0}};
    rd2 = read_sel(ra2, mem_r[ra2], hit2_s, merged_s);
  end

endmodule

// File: tb/tb_regfile_n.sv
// tb_regfile_n
// Drives three builds of regfile_n in parallel:
//   u_a : defaults (32-bit, 32 regs, zero register, bypass)
//   u_b : 32-bit, 32 regs, ordinary register 0, no bypass
//   u_c : 16-bit, 8 regs, zero register, bypass
// Directed vectors, a reset-mid-operation sequence and a random sweep
// against a small reference model.
module tb_regfile_n;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

  logic        we_c;
  logic [2:0]  wa_c, ra1_c, ra2_c;
  logic [15:0] wd_c;
  logic [1:0]  wbe_c;
  logic [15:0] rd1_c, rd2_c;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [31:0] mc [8];

  always #5 clk = ~clk;

  regfile_n u_a (
    .clk(clk), .clr(clr), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .ra1(ra1), .rd1(rd1_a), .ra2(ra2), .rd2(rd2_a)
  );

  regfile_n #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .clr(clr), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .ra1(ra1), .rd1(rd1_b), .ra2(ra2), .rd2(rd2_b)
  );

  regfile_n #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_c (
    .clk(clk), .clr(clr), .we(we_c), .wa(wa_c), .wd(wd_c), .wbe(wbe_c),
    .ra1(ra1_c), .rd1(rd1_c), .ra2(ra2_c), .rd2(rd2_c)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] b1;
    logic [31:0] b2;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] stored, input logic [4:0] ra_i,
                                         input logic [4:0] wa_i, input logic we_i,
                                         input logic [31:0] wd_i, input logic [3:0] be_i,
                                         input bit zr, input bit bp, input logic clr_i);
    if (!clr_i) return 32'h0;
    if (zr && ra_i == 5'd0) return 32'h0;
    if (bp && we_i && !(zr && wa_i == 5'd0) && ra_i == wa_i) return mrg(stored, wd_i, be_i);
    return stored;
  endfunction

  task automatic idle();
    we = 1'b0; wa = 5'd0; wd = 32'h0; wbe = 4'h0; ra1 = 5'd0; ra2 = 5'd0;
    we_c = 1'b0; wa_c = 3'd0; wd_c = 16'h0; wbe_c = 2'b0; ra1_c = 3'd0; ra2_c = 3'd0;
  endtask

  initial begin
    //           we    wa     wd            wbe   ra1    ra2    a1            a2            b1            b2
    vecs[0] = '{1'b1, 5'd7, 32'hFFFFFFFF, 4'hF, 5'd7, 5'd6, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd7, 32'h00000000, 4'h5, 5'd7, 5'd8, 32'hFF00FF00, 32'h0,        32'hFFFFFFFF, 32'h0};
    vecs[2] = '{1'b0, 5'd0, 32'h00000000, 4'h0, 5'd7, 5'd6, 32'hFF00FF00, 32'h0,        32'hFF00FF00, 32'h0};
    vecs[3] = '{1'b1, 5'd6, 32'h12345678, 4'hF, 5'd6, 5'd7, 32'h12345678, 32'hFF00FF00, 32'h0,        32'hFF00FF00};
    vecs[4] = '{1'b1, 5'd6, 32'hFFFFFFFF, 4'h0, 5'd6, 5'd8, 32'h12345678, 32'h0,        32'h12345678, 32'h0};
    vecs[5] = '{1'b1, 5'd0, 32'hA5A5A5A5, 4'hF, 5'd0, 5'd6, 32'h0,        32'h12345678, 32'h0,        32'h12345678};
    vecs[6] = '{1'b0, 5'd0, 32'h00000000, 4'h0, 5'd0, 5'd7, 32'h0,        32'hFF00FF00, 32'hA5A5A5A5, 32'hFF00FF00};
    vecs[7] = '{1'b1, 5'd3, 32'h11223344, 4'hF, 5'd5, 5'd3, 32'h0,        32'h11223344, 32'h0,        32'h0};
    vecs[8] = '{1'b1, 5'd3, 32'hAABBCCDD, 4'h3, 5'd3, 5'd3, 32'h1122CCDD, 32'h1122CCDD, 32'h11223344, 32'h11223344};
    vecs[9] = '{1'b0, 5'd0, 32'h00000000, 4'h0, 5'd3, 5'd6, 32'h1122CCDD, 32'h12345678, 32'h1122CCDD, 32'h12345678};

    clr = 1'b0;
    idle();
    ra2 = 5'd31; ra1_c = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_rd1", rd1_a, 32'h0);
    chk("rst_a_rd2", rd2_a, 32'h0);
    chk("rst_b_rd2", rd2_b, 32'h0);
    chk("rst_c_rd1", {16'h0, rd1_c}, 32'h0);
    clr = 1'b1;

    // Directed vectors, one per cycle, checked before the write edge.
    for (int i = 0; i < 10; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd; wbe = vecs[i].wbe;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #4;
      chk($sformatf("vec%0d_a_rd1", i), rd1_a, vecs[i].a1);
      chk($sformatf("vec%0d_a_rd2", i), rd2_a, vecs[i].a2);
      chk($sformatf("vec%0d_b_rd1", i), rd1_b, vecs[i].b1);
      chk($sformatf("vec%0d_b_rd2", i), rd2_b, vecs[i].b2);
      @(posedge clk); #1;
    end

    // Reset mid-operation.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; wbe = 4'hF;
    @(posedge clk); #1;
    wa = 5'd31; wd = 32'h12345678;
    @(posedge clk); #1;
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd31;
    #2;
    chk("mid_pre_a_rd1", rd1_a, 32'hDEADBEEF);
    chk("mid_pre_a_rd2", rd2_a, 32'h12345678);
    chk("mid_pre_b_rd1", rd1_b, 32'hDEADBEEF);
    clr = 1'b0;
    #1;
    chk("mid_clr_a_rd1", rd1_a, 32'h0);
    chk("mid_clr_a_rd2", rd2_a, 32'h0);
    chk("mid_clr_b_rd2", rd2_b, 32'h0);
    we = 1'b1; wd = 32'hFFFFFFFF;
    #1;
    chk("mid_clr_byp_a_rd1", rd1_a, 32'h0);
    we = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    #3;
    chk("mid_post_a_rd1", rd1_a, 32'h0);
    chk("mid_post_a_rd2", rd2_a, 32'h0);
    chk("mid_post_b_rd1", rd1_b, 32'h0);
    @(posedge clk); #1;

    // Random sweep; every register is zero after the reset above.
    for (int i = 0; i < 32; i++) begin ma[i] = 32'h0; mb[i] = 32'h0; end
    for (int i = 0; i < 8; i++) mc[i] = 32'h0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      we   = ($urandom_range(0, 3) != 0);
      wa   = 5'($urandom_range(0, 31));
      wd   = $urandom;
      wbe  = 4'($urandom_range(0, 15));
      ra1  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      we_c  = ($urandom_range(0, 3) != 0);
      wa_c  = 3'($urandom_range(0, 7));
      wd_c  = 16'($urandom_range(0, 65535));
      wbe_c = 2'($urandom_range(0, 3));
      ra1_c = ($urandom_range(0, 2) == 0) ? wa_c : 3'($urandom_range(0, 7));
      ra2_c = ($urandom_range(0, 2) == 0) ? wa_c : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        clr = 1'b0;
        for (int i = 0; i < 32; i++) begin ma[i] = 32'h0; mb[i] = 32'h0; end
        for (int i = 0; i < 8; i++) mc[i] = 32'h0;
      end
      #4;
      chk("rnd_a_rd1", rd1_a, exp_rd(ma[ra1], ra1, wa, we, wd, wbe, 1'b1, 1'b1, clr));
      chk("rnd_a_rd2", rd2_a, exp_rd(ma[ra2], ra2, wa, we, wd, wbe, 1'b1, 1'b1, clr));
      chk("rnd_b_rd1", rd1_b, exp_rd(mb[ra1], ra1, wa, we, wd, wbe, 1'b0, 1'b0, clr));
      chk("rnd_b_rd2", rd2_b, exp_rd(mb[ra2], ra2, wa, we, wd, wbe, 1'b0, 1'b0, clr));
      chk("rnd_c_rd1", {16'h0, rd1_c}, exp_rd(mc[ra1_c], {2'b0, ra1_c}, {2'b0, wa_c}, we_c,
                                               {16'h0, wd_c}, {2'b0, wbe_c}, 1'b1, 1'b1, clr));
      chk("rnd_c_rd2", {16'h0, rd2_c}, exp_rd(mc[ra2_c], {2'b0, ra2_c}, {2'b0, wa_c}, we_c,
                                               {16'h0, wd_c}, {2'b0, wbe_c}, 1'b1, 1'b1, clr));
      if (clr) begin
        if (we && wa != 5'd0) ma[wa] = mrg(ma[wa], wd, wbe);
        if (we) mb[wa] = mrg(mb[wa], wd, wbe);
        if (we_c && wa_c != 3'd0) mc[wa_c] = mrg(mc[wa_c], {16'h0, wd_c}, {2'b0, wbe_c});
      end
      @(posedge clk); #1;
      if (!clr) clr = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
